// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative MULT/MULTU/DIV/DIVU unit. It handles one partial
//               product or one quotient bit per cycle and writes HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cancel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;      // product, or quotient in the low half
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dbz_pend_q, dbz_pend_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            dbz_q, dbz_d;

    logic            w_a_neg, w_b_neg;
    logic [W-1:0]    w_a_abs, w_b_abs;
    logic [W:0]      w_mul_sum;
    logic [W:0]      w_div_diff;
    logic [W-1:0]    w_div_keep;
    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_quo_fix, w_rem_fix;

    assign w_a_neg = ~op[0] & a[W-1];
    assign w_b_neg = ~op[0] & b[W-1];
    assign w_a_abs = w_a_neg ? -a : a;
    assign w_b_abs = w_b_neg ? -b : b;

    assign w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
    // The shifted partial remainder is W+1 bits; a borrow in the top bit means restore.
    assign w_div_diff = {rem_q, acc_q[W-1]} - {1'b0, mcand_q};
    assign w_div_keep = {rem_q[W-2:0], acc_q[W-1]};

    assign w_prod_fix = neg_res_q ? -acc_q : acc_q;
    assign w_quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign w_rem_fix  = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        mcand_d    = mcand_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_CALC;
                    op_d       = op;
                    cnt_d      = '0;
                    rem_d      = '0;
                    neg_res_d  = w_a_neg ^ w_b_neg;
                    neg_rem_d  = w_a_neg;
                    dbz_pend_d = op[1] && (b == '0);
                    if (op[1]) begin
                        // A zero divisor keeps the raw dividend so it can be reported in HI.
                        acc_d   = {{W{1'b0}}, ((b == '0) ? a : w_a_abs)};
                        mcand_d = w_b_abs;
                    end else begin
                        acc_d   = {{W{1'b0}}, w_b_abs};
                        mcand_d = w_a_abs;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (dbz_pend_q) begin
                    state_d = ST_DONE;
                    hi_d    = acc_q[W-1:0];
                    lo_d    = {W{1'b1}};
                    dbz_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q[1]) begin
                        if (w_div_diff[W]) begin
                            rem_d = w_div_keep;
                            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
                        end else begin
                            rem_d = w_div_diff[W-1:0];
                            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
                        end
                    end else begin
                        acc_d = {w_mul_sum, acc_q[W-1:1]};
                    end
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    dbz_d   = 1'b0;
                    if (op_q[1]) begin
                        hi_d = w_rem_fix;
                        lo_d = w_quo_fix;
                    end else begin
                        hi_d = w_prod_fix[2*W-1:W];
                        lo_d = w_prod_fix[W-1:0];
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            mcand_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            mcand_q    <= mcand_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Directed self-checking bench for alu_muldiv_seq (W=32 and W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, cancel = 1'b0, out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, dbz;
    logic [31:0] hi, lo;

    logic        in_valid8 = 1'b0, cancel8 = 1'b0, out_ready8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks   = 0;
    int failures = 0;

    alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .cancel(cancel), .out_valid(out_valid), .out_ready(out_ready),
        .hi(hi), .lo(lo), .div_by_zero(dbz)
    );

    alu_muldiv_seq #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .a(a8), .b(b8), .cancel(cancel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    // Drive a request so that it is accepted at the next rising edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid; also track in_ready while busy.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", dbz); end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int lat; bit busy_ok;
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, busy_ok);
        checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        checks++; if (!busy_ok) begin failures++; $display("FAIL mult_in_ready_busy: got 1 expected 0"); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mult_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_multu();
        int lat; bit busy_ok;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, busy_ok);
        checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo); end
        consume();
    endtask

    task automatic test_multu8();
        int lat;
        in_valid8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 9) begin failures++; $display("FAIL multu8_latency: got %0d expected 9", lat); end
        checks++; if ({hi8, lo8} !== 16'hFE01) begin failures++; $display("FAIL multu8_result: got %h_%h expected fe_01", hi8, lo8); end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_div();
        int lat; bit busy_ok;
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, busy_ok);
        checks++; if (lat != 33) begin failures++; $display("FAIL div_latency: got %0d expected 33", lat); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg: got %h_%h expected ffffffff_fffffffd", hi, lo); end
        consume();
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, busy_ok);
        checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end
        consume();
    endtask

    task automatic test_divu_zero();
        int lat; bit busy_ok;
        start_op(2'b11, 32'd100, 32'd0);
        wait_done(lat, busy_ok);
        checks++; if (lat != 1) begin failures++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        checks++; if ({hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin failures++; $display("FAIL dbz_result: got %h_%h expected 00000064_ffffffff", hi, lo); end
        checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %b expected 1", dbz); end
        consume();
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(lat, busy_ok);
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL divu_result: got hi=%0d lo=%0d expected 2 14", hi, lo); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL divu_dbz_clear: got %b expected 0", dbz); end
        consume();
    endtask

    task automatic test_cancel();
        int lat; bit busy_ok; bit never_valid;
        start_op(2'b01, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cancel_in_ready: got %b expected 1", in_ready); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL cancel_hold: got hi=%0d lo=%0d expected 2 14", hi, lo); end
        never_valid = 1'b1;
        repeat (40) begin
            if (out_valid !== 1'b0) never_valid = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (!never_valid) begin failures++; $display("FAIL cancel_out_valid: got 1 expected 0"); end
        start_op(2'b01, 32'd5, 32'd6);
        wait_done(lat, busy_ok);
        checks++; if (hi !== 32'd0 || lo !== 32'd30) begin failures++; $display("FAIL cancel_rerun: got hi=%0d lo=%0d expected 0 30", hi, lo); end
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        cancel = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || hi !== 32'd0 || lo !== 32'd30) stable = 1'b0;
        end
        cancel = 1'b0;
        checks++; if (!stable) begin failures++; $display("FAIL backpressure_stable: got out_valid=%b hi=%0d lo=%0d expected 1 0 30", out_valid, hi, lo); end
        consume();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL backpressure_release: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat; bit busy_ok; bit quiet;
        start_op(2'b11, 32'd9, 32'd0);
        wait_done(lat, busy_ok);
        consume();
        start_op(2'b00, 32'd3, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset_hs: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
        checks++; if ({hi, lo} !== 64'h0 || dbz !== 1'b0) begin failures++; $display("FAIL midreset_regs: got %h_%h dbz=%b expected 0_0 0", hi, lo, dbz); end
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL midreset_discard: got out_valid=1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_multu8();
        test_div();
        test_divu_zero();
        test_cancel();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit that extends the datapath ALU with MULT, MULTU, DIV and DIVU.
- Sits beside the combinational ALU in the execute stage and writes the HI/LO result registers.
- Uses a valid/ready request/response handshake so the pipeline can stall or cancel around it.
- Iterative: one partial-product or one quotient bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand width W; legal for W >= 4; hi, lo and the operands are W bits each.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request; high only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  W  multiplicand / dividend
- b  input  W  multiplier / divisor
- cancel  input  1  abort the in-flight operation (pipeline flush)
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- hi  output  W  MULT*: upper half of product; DIV*: remainder
- lo  output  W  MULT*: lower half of product; DIV*: quotient
- div_by_zero  output  1  last completed DIV/DIVU had b == 0

Behaviour:
- Reset: state = IDLE, hi = 0, lo = 0, out_valid = 0, div_by_zero = 0, in_ready = 1. Reset overrides every other input, including mid-operation; a pending result is discarded.
- States: IDLE, CALC, FIX, DONE.
- Accept: in IDLE, in_valid = 1 at edge k latches op and the operands.
  - Signed ops latch absolute values plus the result sign bits.
  - Step counter is cleared; state -> CALC.
- CALC: one step per cycle.
  - Multiply: shift-add on a 2W-bit accumulator.
  - Divide: restoring shift-subtract on a W+1-bit remainder.
  - After W steps (edge k+W): state -> FIX.
- FIX, one cycle:
  - Signed multiply: negate the 2W product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write hi and lo; state -> DONE at edge k+W+1.
- Latency: out_valid is first high in the cycle after edge k+W+1, i.e. W+1 cycles after accept (33 for W = 32).
- DONE: out_valid = 1, and hi/lo/div_by_zero are stable. When out_ready = 1, state -> IDLE at that edge. out_valid may stay high indefinitely under backpressure.
- hi, lo and div_by_zero hold their values until the next completed operation; they are not cleared on leaving DONE.
- Divide by zero (DIV or DIVU with b == 0): skip CALC and FIX; state -> DONE at edge k+1 (latency 1). Result: lo = all ones, hi = a, div_by_zero = 1. Any other completion clears div_by_zero.
- Signed overflow: DIV with a = most-negative and b = -1 gives lo = most-negative, hi = 0. There is no trap and no flag.
- Widths: all internal arithmetic is unsigned magnitude. MULTU and DIVU never negate.
- Cancel:
  - cancel = 1 in CALC or FIX: state -> IDLE at the next edge; hi/lo/div_by_zero are unchanged and out_valid never rises.
  - cancel is ignored in IDLE and DONE.
  - cancel takes priority over the step/FIX update in the same cycle.
- No new request is accepted in the same cycle as the DONE->IDLE transition, because in_ready is 0 in DONE.

Test Plan:
- MULT a = 0xFFFFFFFD (-3), b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; out_valid rises exactly 33 cycles after the accept edge; in_ready = 0 throughout.
- MULTU a = b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; also re-check with DATA_WIDTH = 8: a = b = 0xFF -> hi = 0xFE, lo = 0x01, latency 9.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU a = 100, b = 0 -> out_valid after 1 cycle, lo = 0xFFFFFFFF, hi = 100, div_by_zero = 1; a following DIVU 100/7 -> lo = 14, hi = 2, div_by_zero = 0.
- Start MULTU 5*6, assert cancel 10 cycles after accept -> in_ready = 1 next cycle, hi/lo keep the prior values, out_valid stays 0; then MULTU 5*6 -> lo = 30, hi = 0.
- Hold out_ready = 0 for 5 cycles in DONE -> out_valid and hi/lo stable and cancel ignored; assert rst mid-CALC -> all outputs return to their reset values on the next edge.
